// File: rtl/maze_pkg.sv
// Shared maze-search definitions: location width, move directions, replay stack states.
// Pure declarations; no logic, latency or backpressure of its own.
package maze_pkg;

  localparam int LOC_W = 8;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REPLAY,
    DONE
  } state_t;

endpackage

// File: rtl/path_replay_stack_dir_decode.sv
// Move direction from prev_loc to cur_loc ({y,x}) and a 4-adjacency flag.
// Purely combinational: zero latency, no backpressure.
module dir_decode
  import maze_pkg::*;
#(
  parameter int LOC_W = maze_pkg::LOC_W
) (
  input  logic [LOC_W-1:0] prev_loc,
  input  logic [LOC_W-1:0] cur_loc,
  output logic [1:0]       dir,
  output logic             adj
);

  localparam int CW = LOC_W / 2;
  localparam logic [CW:0] ONE = {{CW{1'b0}}, 1'b1};

  // One extra bit so edge cells never appear adjacent through wraparound.
  logic [CW:0] px, py, cx, cy;
  logic mv_up, mv_right, mv_down, mv_left;

  assign px = {1'b0, prev_loc[CW-1:0]};
  assign py = {1'b0, prev_loc[LOC_W-1:CW]};
  assign cx = {1'b0, cur_loc[CW-1:0]};
  assign cy = {1'b0, cur_loc[LOC_W-1:CW]};

  assign mv_up    = (cx == px) && (cy + ONE == py);
  assign mv_right = (cy == py) && (cx == px + ONE);
  assign mv_down  = (cx == px) && (cy == py + ONE);
  assign mv_left  = (cy == py) && (cx + ONE == px);

  assign adj = mv_up | mv_right | mv_down | mv_left;

  always_comb begin
    dir = DIR_UP;
    if (mv_right)     dir = DIR_RIGHT;
    else if (mv_down) dir = DIR_DOWN;
    else if (mv_left) dir = DIR_LEFT;
  end

endmodule

// File: rtl/path_replay_stack.sv
// Location stack for maze search with bottom-to-top replay of {location, direction} over valid/ready.
// Stack ops land on the sampling edge; replay gives one entry per cycle and holds out_loc/out_dir while out_ready is low.
module path_replay_stack
  import maze_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LOC_W = maze_pkg::LOC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [LOC_W-1:0] din,
  output logic [LOC_W-1:0] top,
  output logic             empty,
  output logic             full,
  input  logic             replay_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOC_W-1:0] out_loc,
  output logic [1:0]       out_dir,
  output logic             replay_done,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   SP_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   SP_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] RD_ONE = {{(AW - 1){1'b0}}, 1'b1};

  logic [LOC_W-1:0] mem [DEPTH];

  state_t        state, state_nxt;
  logic [AW:0]   sp, sp_nxt, sp_m1;
  logic [AW-1:0] rd_ptr, rd_nxt, rd_prev, waddr;
  logic          we, err_set;
  logic [LOC_W-1:0] cur_loc, prev_loc;
  logic [1:0]    dec_dir;
  logic          dec_adj;

  assign sp_m1   = sp - SP_ONE;
  assign rd_prev = rd_ptr - RD_ONE;
  assign empty   = (sp == '0);
  assign full    = (sp == SP_MAX);
  assign top     = empty ? '0 : mem[sp_m1[AW-1:0]];

  assign cur_loc  = mem[rd_ptr];
  assign prev_loc = mem[rd_prev];

  dir_decode #(.LOC_W(LOC_W)) u_dir_decode (
    .prev_loc (prev_loc),
    .cur_loc  (cur_loc),
    .dir      (dec_dir),
    .adj      (dec_adj)
  );

  // The first replayed entry has no predecessor, so it always reports direction 0.
  assign out_valid = (state == REPLAY);
  assign out_loc   = out_valid ? cur_loc : '0;
  assign out_dir   = (out_valid && rd_ptr != '0 && dec_adj) ? dec_dir : 2'd0;

  always_comb begin
    state_nxt   = state;
    sp_nxt      = sp;
    rd_nxt      = rd_ptr;
    we          = 1'b0;
    waddr       = sp[AW-1:0];
    err_set     = 1'b0;
    replay_done = 1'b0;
    case (state)
      IDLE: begin
        if (replay_start) begin
          if (!empty) begin
            rd_nxt    = '0;
            state_nxt = REPLAY;
          end else begin
            state_nxt = DONE;
          end
        end else if (push && (!pop || empty)) begin
          if (full) begin
            err_set = 1'b1;
          end else begin
            we     = 1'b1;
            sp_nxt = sp + SP_ONE;
          end
        end else if (push && pop) begin
          we    = 1'b1;
          waddr = sp_m1[AW-1:0];
        end else if (pop) begin
          if (empty) err_set = 1'b1;
          else       sp_nxt  = sp_m1;
        end
      end
      REPLAY: begin
        if (out_ready) begin
          if (rd_ptr != '0 && !dec_adj) err_set = 1'b1;
          if ({1'b0, rd_ptr} == sp_m1) state_nxt = DONE;
          else                         rd_nxt    = rd_ptr + RD_ONE;
        end
      end
      DONE: begin
        replay_done = 1'b1;
        sp_nxt      = '0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sp     <= '0;
      rd_ptr <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      sp     <= sp_nxt;
      rd_ptr <= rd_nxt;
      err    <= err | err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

endmodule

// File: tb/tb_path_replay_stack.sv
// Bench for path_replay_stack: stack-op vector table plus scoreboarded replay runs and reset/overflow corners.
module tb_path_replay_stack;

  logic       clk = 1'b0;
  logic       rst, push, pop, replay_start, out_ready;
  logic [7:0] din;
  logic [7:0] top, out_loc;
  logic       empty, full, out_valid, replay_done, err;
  logic [1:0] out_dir;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  path_replay_stack #(.DEPTH(256), .LOC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .din          (din),
    .top          (top),
    .empty        (empty),
    .full         (full),
    .replay_start (replay_start),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_loc      (out_loc),
    .out_dir      (out_dir),
    .replay_done  (replay_done),
    .err          (err)
  );

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] top;
    logic       empty;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic [7:0] loc;
    logic [1:0] dir;
  } exp_t;

  vec_t       vecs[10];
  exp_t       sb[$];
  logic [7:0] plan_loc[$];
  logic [1:0] plan_dir[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push = 1'b0; pop = 1'b0; din = 8'h00; replay_start = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_one(input logic [7:0] v);
    push = 1'b1; din = v;
    tick();
    push = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready toggles and push/pop are hammered during replay
  task automatic run_replay(input int mode, input int exp_done);
    int   cyc;
    bit   done, stalled;
    logic [7:0] hl;
    logic [1:0] hd;
    exp_t e;
    foreach (plan_loc[i]) push_one(plan_loc[i]);
    sb.delete();
    foreach (plan_loc[i]) sb.push_back({plan_loc[i], plan_dir[i]});
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    cyc = 0; done = 0; stalled = 0; hl = '0; hd = '0;
    while (!done && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : cyc[0];
      if (mode == 1) begin push = 1'b1; pop = 1'b1; din = 8'hAA; end
      @(negedge clk);
      cyc++;
      if (stalled && out_valid) begin
        check("hold_loc", out_loc, hl);
        check("hold_dir", out_dir, hd);
      end
      stalled = 0;
      if (replay_done) begin
        done = 1;
        if (exp_done > 0) check("done_cycle", cyc, exp_done);
      end else if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) check("extra_out", 1, 0);
          else begin
            e = sb.pop_front();
            check("out_loc", out_loc, e.loc);
            check("out_dir", out_dir, e.dir);
          end
        end else begin
          stalled = 1; hl = out_loc; hd = out_dir;
        end
      end
      @(posedge clk);
      #1;
    end
    push = 1'b0; pop = 1'b0; out_ready = 1'b0;
    check("replay_finished", done, 1);
    check("sb_drained", sb.size(), 0);
    check("empty_after", empty, 1);
    check("valid_after", out_valid, 0);
  endtask

  initial begin
    int seen_done;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h07, 8'h07, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};

    do_reset();
    check("rst_top", top, 8'h00);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", replay_done, 0);
    check("rst_loc", out_loc, 8'h00);
    check("rst_dir", out_dir, 2'd0);

    for (int i = 0; i < 10; i++) begin
      push = vecs[i].push; pop = vecs[i].pop; din = vecs[i].din;
      tick();
      push = 1'b0; pop = 1'b0;
      check($sformatf("vec%0d_top", i), top, vecs[i].top);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
      check($sformatf("vec%0d_full", i), full, 0);
      check($sformatf("vec%0d_err", i), err, vecs[i].err);
    end

    // Continuous ready, 4 entries: done on cycle 5
    do_reset();
    plan_loc = '{8'h00, 8'h01, 8'h11, 8'h12};
    plan_dir = '{2'd0, 2'd1, 2'd2, 2'd1};
    run_replay(0, 5);
    check("replay_err", err, 0);

    // Toggling ready with push/pop noise during replay
    plan_loc = '{8'h00, 8'h01, 8'h11, 8'h12};
    plan_dir = '{2'd0, 2'd1, 2'd2, 2'd1};
    run_replay(1, 0);
    check("noise_err", err, 0);

    // Up and left moves
    plan_loc = '{8'h12, 8'h02, 8'h01};
    plan_dir = '{2'd0, 2'd0, 2'd3};
    run_replay(0, 4);

    // Replay of an empty stack goes straight to done
    plan_loc = {};
    plan_dir = {};
    run_replay(0, 1);
    check("empty_replay_err", err, 0);

    // Non-adjacent step
    plan_loc = '{8'h00, 8'h22};
    plan_dir = '{2'd0, 2'd0};
    run_replay(0, 3);
    check("nonadj_err", err, 1);

    // Overflow: 256 accepted, 257th rejected
    do_reset();
    for (int i = 0; i < 256; i++) push_one(8'(i));
    check("fill_full", full, 1);
    check("fill_top", top, 8'hFF);
    check("fill_err", err, 0);
    push_one(8'h5A);
    check("over_full", full, 1);
    check("over_top", top, 8'hFF);
    check("over_err", err, 1);
    pop = 1'b1; tick(); pop = 1'b0;
    check("after_pop_full", full, 0);
    check("after_pop_top", top, 8'hFE);

    // Reset while entry 2 is on the output
    do_reset();
    foreach (plan_loc[i]) plan_loc.delete();
    push_one(8'h00); push_one(8'h01); push_one(8'h11); push_one(8'h12);
    replay_start = 1'b1; tick(); replay_start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_entry2", out_loc, 8'h11);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_empty", empty, 1);
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (replay_done) seen_done++;
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (replay_done) seen_done++;
      @(negedge clk);
    end
    check("mid_no_done", seen_done, 0);
    out_ready = 1'b0;
    tick();
    plan_loc = '{8'h33, 8'h34};
    plan_dir = '{2'd0, 2'd1};
    run_replay(0, 3);
    check("post_rst_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/path_replay_stack.md
# path_replay_stack

Location stack for the maze-search datapath, plus in-order path replay. During search the controller pushes each location it enters and pops on dead ends. Once it reaches the destination, the stack contents are replayed from bottom to top. Each location is emitted together with the move direction that led to it, over a valid/ready stream to the path output stage.

## Interface
Parameters:
- DEPTH, 256 — stack entries; one per maze cell of the 16x16 maze.
- LOC_W, 8 — location width, {y[7:4], x[3:0]}.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- push  in  1  push din; sampled in IDLE only.
- pop  in  1  pop top; sampled in IDLE only.
- din  in  LOC_W  location to push.
- top  out  LOC_W  current top entry; 0 when empty.
- empty  out  1  sp == 0.
- full  out  1  sp == DEPTH.
- replay_start  in  1  begin replay; sampled in IDLE only.
- out_valid  out  1  replay entry valid.
- out_ready  in  1  consumer accepts.
- out_loc  out  LOC_W  replayed location.
- out_dir  out  2  move into out_loc: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1).
- replay_done  out  1  one-cycle pulse at end of replay.
- err  out  1  sticky error flag; cleared only by rst.

## Operation
- sp has width $clog2(DEPTH)+1. rd_ptr has width $clog2(DEPTH).
- The storage array is not reset. All other registers are.

States:
- IDLE: stack operations and replay_start are accepted here.
  - push only, not full: mem[sp] <= din, sp++.
  - push only, full: no write; err <= 1.
  - pop only, not empty: sp--.
  - pop only, empty: no change; err <= 1.
  - push and pop together, not empty: mem[sp-1] <= din (replace top); sp unchanged.
  - push and pop together, empty: treated as push only; no error.
  - replay_start, sp > 0: rd_ptr <= 0; go to REPLAY.
  - replay_start, sp == 0: go to DONE.
  - If replay_start coincides with push or pop, replay_start wins and the stack operation is dropped.
- REPLAY:
  - out_valid = 1; out_loc = mem[rd_ptr].
  - out_dir = step(mem[rd_ptr-1], mem[rd_ptr]). When rd_ptr == 0, out_dir = 0.
  - push and pop are ignored and do not set err.
  - On out_valid && out_ready with rd_ptr == sp-1: go to DONE. Otherwise rd_ptr++.
  - If consecutive locations are not 4-adjacent: out_dir = 0 and err <= 1 on the transfer cycle. The replay continues.
- DONE:
  - replay_done = 1 for exactly one cycle.
  - sp <= 0 (stack cleared for the next run).
  - Go to IDLE.

Combinational outputs:
- top = empty ? 0 : mem[sp-1].
- out_valid = (state == REPLAY).
- out_loc and out_dir are 0 outside REPLAY.

Reset:
- All outputs go to 0 except empty, which goes to 1.
- sp = 0, rd_ptr = 0, state = IDLE, err = 0.
- A reset mid-replay aborts the replay immediately. No replay_done pulse is generated.

## Timing
- Push and pop take effect on the sampling edge. top, empty and full reflect the new sp in the following cycle.
- out_valid rises the cycle after the edge that sampled replay_start.
- Holding out_ready = 1 gives one entry per cycle.
- For N entries with continuous ready, replay_done is high N+1 cycles after replay_start is sampled.
- While out_ready = 0, out_loc and out_dir hold stable.
- Array read is asynchronous (register file), so there are no read bubbles.

## Structure
- maze_pkg holds:
  - LOC_W.
  - Direction constants DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT, shared with the search controller.
  - State enum {IDLE, REPLAY, DONE}.
- Sub-module dir_decode (combinational): inputs prev_loc and cur_loc; outputs dir[1:0] and adj (1 when the two locations are 4-adjacent).
- Everything else is flat in this module.

## Test plan
- Reset, then push 0x00, 0x01, 0x11 and pop once. Expect top = 0x01, empty = 0, err = 0.
- Push 0x00, 0x01, 0x11, 0x12, then replay_start with out_ready = 1. Expect:
  - out_loc sequence 0x00, 0x01, 0x11, 0x12.
  - out_dir sequence 0, 1, 2, 1.
  - replay_done 5 cycles after start; empty = 1 afterwards.
- Same replay, but out_ready toggles 0/1 every cycle. Expect the same sequence, outputs held while ready = 0, and no duplicates or drops.
- Pop on empty, and push DEPTH+1 times. Expect err = 1, sp capped at DEPTH, full = 1, top = last accepted value.
- Push 0x00 then 0x22 (non-adjacent), then replay. Expect out_dir = 0 for 0x22, err = 1, replay completes.
- Assert rst during REPLAY at entry 2. Expect out_valid = 0 immediately, empty = 1, no replay_done pulse, and a normal push/replay afterwards.
